// File: rtl/xgemac_tx_arbiter.sv
// Packet-atomic two-source round-robin arbiter in front of the XGEMAC pkt_tx port.
// Define XGEMAC_TX_ARB_STATS_EN to add per-source packet counters and a drop counter.
module xgemac_tx_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int MOD_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_val,
  input  logic                  s0_sop,
  input  logic                  s0_eop,
  input  logic [MOD_WIDTH-1:0]  s0_mod,
  output logic                  s0_rdy,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_val,
  input  logic                  s1_sop,
  input  logic                  s1_eop,
  input  logic [MOD_WIDTH-1:0]  s1_mod,
  output logic                  s1_rdy,
  output logic [DATA_WIDTH-1:0] pkt_tx_data,
  output logic                  pkt_tx_val,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic [MOD_WIDTH-1:0]  pkt_tx_mod,
  input  logic                  pkt_tx_full,
  output logic                  drop_err
`ifdef XGEMAC_TX_ARB_STATS_EN
  ,
  output logic [31:0]           s0_pkt_cnt,
  output logic [31:0]           s1_pkt_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [MOD_WIDTH-1:0]  mod_q;
  logic                  val_q, sop_q, eop_q, drop_q;

  logic                  sel, sel_vld, stray;
  logic                  cand0, cand1;
  logic                  beat_val, beat_sop, beat_eop;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [MOD_WIDTH-1:0]  beat_mod;
  logic                  xfer, fwd;

  assign cand0 = s0_val & s0_sop;
  assign cand1 = s1_val & s1_sop;

  // Source selection: candidates (val && sop) beat stray beats; a tie goes to the
  // source that did not finish the previous packet.
  always_comb begin
    sel     = 1'b0;
    sel_vld = 1'b0;
    stray   = 1'b0;
    if (state_q == ST_PKT) begin
      sel     = gnt_q;
      sel_vld = 1'b1;
    end else if (cand0 && cand1) begin
      sel     = ~last_q;
      sel_vld = 1'b1;
    end else if (cand0 || cand1) begin
      sel     = cand1;
      sel_vld = 1'b1;
    end else if (s0_val || s1_val) begin
      sel     = ~s0_val;
      sel_vld = 1'b1;
      stray   = 1'b1;
    end
  end

  assign s0_rdy    = rst & sel_vld & ~sel & ~pkt_tx_full;
  assign s1_rdy    = rst & sel_vld &  sel & ~pkt_tx_full;

  assign beat_val  = sel ? s1_val  : s0_val;
  assign beat_sop  = sel ? s1_sop  : s0_sop;
  assign beat_eop  = sel ? s1_eop  : s0_eop;
  assign beat_data = sel ? s1_data : s0_data;
  assign beat_mod  = sel ? s1_mod  : s0_mod;
  assign xfer      = sel_vld & ~pkt_tx_full & beat_val;
  assign fwd       = xfer & ~stray;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    if (fwd) begin
      if (state_q == ST_IDLE) begin
        gnt_d = sel;
        if (beat_eop) last_d  = sel;
        else          state_d = ST_PKT;
      end else if (beat_eop) begin
        state_d = ST_IDLE;
        last_d  = gnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      val_q   <= fwd;
      sop_q   <= fwd & beat_sop;
      eop_q   <= fwd & beat_eop;
      drop_q  <= xfer & stray;
      // data/mod hold their last value on idle cycles
      if (fwd) begin
        data_q <= beat_data;
        mod_q  <= beat_mod;
      end
    end
  end

  assign pkt_tx_data = data_q;
  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = sop_q;
  assign pkt_tx_eop  = eop_q;
  assign pkt_tx_mod  = mod_q;
  assign drop_err    = drop_q;

`ifdef XGEMAC_TX_ARB_STATS_EN
  logic [31:0] s0_cnt_q, s1_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_cnt_q   <= '0;
      s1_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (fwd && beat_eop && !sel) s0_cnt_q <= s0_cnt_q + 32'd1;
      if (fwd && beat_eop &&  sel) s1_cnt_q <= s1_cnt_q + 32'd1;
      if (xfer && stray)           drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign s0_pkt_cnt = s0_cnt_q;
  assign s1_pkt_cnt = s1_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// Self-checking bench for xgemac_tx_arbiter: directed scenarios plus a randomized
// packet stream checked against a packet-level round-robin model.
module tb_xgemac_tx_arbiter;

  localparam int DW = 64;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_data, s1_data, pkt_tx_data;
  logic          s0_val, s0_sop, s0_eop, s0_rdy;
  logic          s1_val, s1_sop, s1_eop, s1_rdy;
  logic [MW-1:0] s0_mod, s1_mod, pkt_tx_mod;
  logic          pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full, drop_err;
`ifdef XGEMAC_TX_ARB_STATS_EN
  logic [31:0]   s0_pkt_cnt, s1_pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  xgemac_tx_arbiter #(.DATA_WIDTH(DW), .MOD_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_val(s0_val), .s0_sop(s0_sop), .s0_eop(s0_eop),
    .s0_mod(s0_mod), .s0_rdy(s0_rdy),
    .s1_data(s1_data), .s1_val(s1_val), .s1_sop(s1_sop), .s1_eop(s1_eop),
    .s1_mod(s1_mod), .s1_rdy(s1_rdy),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .drop_err(drop_err)
`ifdef XGEMAC_TX_ARB_STATS_EN
    , .s0_pkt_cnt(s0_pkt_cnt), .s1_pkt_cnt(s1_pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    logic          sop;
    logic          eop;
    int            src;
  } beat_t;

  beat_t q0[$], q1[$], exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_last;
  int exp_drops, exp_pkt0, exp_pkt1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic sp, input logic ep,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (s == 0) begin
      s0_val = v; s0_sop = sp; s0_eop = ep; s0_data = d; s0_mod = m;
    end else begin
      s1_val = v; s1_sop = sp; s1_eop = ep; s1_data = d; s1_mod = m;
    end
  endtask

  task automatic idle_inputs();
    set_src(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_src(1, 1'b0, 1'b0, 1'b0, '0, '0);
    pkt_tx_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_last = 1;
    exp_drops = 0; exp_pkt0 = 0; exp_pkt1 = 0;
  endtask

  task automatic check_stats(input string name);
`ifdef XGEMAC_TX_ARB_STATS_EN
    n_checks++;
    if (s0_pkt_cnt !== 32'(exp_pkt0) || s1_pkt_cnt !== 32'(exp_pkt1) ||
        drop_cnt !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL %s stats: got s0=%0d s1=%0d drop=%0d expected s0=%0d s1=%0d drop=%0d",
               name, s0_pkt_cnt, s1_pkt_cnt, drop_cnt, exp_pkt0, exp_pkt1, exp_drops);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic add_packet(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.mod  = MW'($urandom_range(0, 7));
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      b.src  = src;
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // Packet-level round robin: when both sources have a packet waiting, the one
  // that did not send the previous packet goes next; otherwise whoever has one.
  task automatic build_expected();
    int i0 = 0;
    int i1 = 0;
    int pick;
    exp_q.delete();
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) pick = (model_last == 0) ? 1 : 0;
      else                                  pick = (i0 < q0.size()) ? 0 : 1;
      if (pick == 0) begin
        do begin exp_q.push_back(q0[i0]); i0++; end while (!q0[i0-1].eop);
      end else begin
        do begin exp_q.push_back(q1[i1]); i1++; end while (!q1[i1-1].eop);
      end
      model_last = pick;
    end
  endtask

  task automatic run_stream(input string name, input int full_pct, input logic [63:0] full_mask);
    int i0 = 0, i1 = 0, oi = 0, cyc = 0;
    logic t0, t1, er0, er1;
    build_expected();
    while (oi < exp_q.size() && cyc < 3000) begin
      pkt_tx_full = ((cyc < 64) ? full_mask[cyc] : 1'b0) || ($urandom_range(0, 99) < full_pct);
      if (i0 < q0.size()) set_src(0, 1'b1, q0[i0].sop, q0[i0].eop, q0[i0].data, q0[i0].mod);
      else                set_src(0, 1'b0, 1'b0, 1'b0, '0, '0);
      if (i1 < q1.size()) set_src(1, 1'b1, q1[i1].sop, q1[i1].eop, q1[i1].data, q1[i1].mod);
      else                set_src(1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      er0 = !pkt_tx_full && exp_q[oi].src == 0;
      er1 = !pkt_tx_full && exp_q[oi].src == 1;
      n_checks++;
      if ({s0_rdy, s1_rdy} !== {er0, er1}) begin
        n_fail++;
        $display("FAIL %s rdy cyc%0d: got s0=%b s1=%b expected s0=%b s1=%b",
                 name, cyc, s0_rdy, s1_rdy, er0, er1);
      end
      t0 = s0_val && s0_rdy;
      t1 = s1_val && s1_rdy;
      tick();
      if (t0) i0++;
      if (t1) i1++;
      n_checks++;
      if (er0 || er1) begin
        if (pkt_tx_val !== 1'b1 || pkt_tx_data !== exp_q[oi].data || pkt_tx_mod !== exp_q[oi].mod ||
            pkt_tx_sop !== exp_q[oi].sop || pkt_tx_eop !== exp_q[oi].eop || drop_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s beat%0d: got val=%b sop=%b eop=%b data=%h mod=%0d drop=%b expected val=1 sop=%b eop=%b data=%h mod=%0d drop=0",
                   name, oi, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod, drop_err,
                   exp_q[oi].sop, exp_q[oi].eop, exp_q[oi].data, exp_q[oi].mod);
        end
        $display("%s: beat %0d src%0d data=%h sop=%b eop=%b", name, oi, exp_q[oi].src,
                 exp_q[oi].data, exp_q[oi].sop, exp_q[oi].eop);
        if (exp_q[oi].eop) begin
          if (exp_q[oi].src == 0) exp_pkt0++;
          else                    exp_pkt1++;
        end
        oi++;
      end else if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err} !== 4'b0) begin
        n_fail++;
        $display("FAIL %s stall cyc%0d: got val/sop/eop/drop=%b%b%b%b expected 0000",
                 name, cyc, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err);
      end
      cyc++;
    end
    n_checks++;
    if (oi < exp_q.size()) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, oi, exp_q.size());
    end
    idle_inputs();
    tick();
    check_stats(name);
    q0.delete(); q1.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err, s0_rdy, s1_rdy} !== 6'b0 ||
        pkt_tx_data !== '0 || pkt_tx_mod !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got val=%b sop=%b eop=%b drop=%b rdy=%b%b data=%h mod=%0d expected all 0",
               pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err, s0_rdy, s1_rdy, pkt_tx_data, pkt_tx_mod);
    end
    rst = 1'b1;
    model_last = 1;
    exp_drops = 0; exp_pkt0 = 0; exp_pkt1 = 0;
    tick();
    n_checks++;
    if ({pkt_tx_val, drop_err, s0_rdy, s1_rdy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release: got val=%b drop=%b rdy=%b%b expected 0000",
               pkt_tx_val, drop_err, s0_rdy, s1_rdy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_source();
    logic [DW-1:0] d;
    for (int i = 1; i <= 4; i++) begin
      d = DW'(i);
      set_src(0, 1'b1, i == 1, i == 4, d, (i == 4) ? MW'(5) : MW'(0));
      #1;
      n_checks++;
      if ({s0_rdy, s1_rdy} !== 2'b10) begin
        n_fail++;
        $display("FAIL single_rdy beat%0d: got %b%b expected 10", i, s0_rdy, s1_rdy);
      end
      tick();
      n_checks++;
      if (pkt_tx_val !== 1'b1 || pkt_tx_data !== d || pkt_tx_sop !== (i == 1) ||
          pkt_tx_eop !== (i == 4) || (i == 4 && pkt_tx_mod !== MW'(5))) begin
        n_fail++;
        $display("FAIL single_beat%0d: got val=%b sop=%b eop=%b data=%h mod=%0d", i,
                 pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod);
      end
      $display("test_single_source: beat %0d data=%h", i, pkt_tx_data);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (pkt_tx_val !== 1'b0 || pkt_tx_data !== DW'(4) || pkt_tx_mod !== MW'(5)) begin
      n_fail++;
      $display("FAIL single_hold: got val=%b data=%h mod=%0d expected val=0 data=4 mod=5",
               pkt_tx_val, pkt_tx_data, pkt_tx_mod);
    end
    model_last = 0;
    exp_pkt0++;
    check_stats("single_source");
  endtask

  task automatic test_contention();
    do_reset();
    add_packet(0, 3); add_packet(0, 2); add_packet(1, 3);
    run_stream("test_contention", 0, 64'h0);
  endtask

  task automatic test_backpressure();
    add_packet(1, 3);
    run_stream("test_backpressure", 0, 64'hE);
  endtask

  task automatic test_single_beat();
    for (int i = 0; i < 4; i++) begin
      add_packet(0, 1);
      add_packet(1, 1);
    end
    run_stream("test_single_beat", 0, 64'h0);
  endtask

  task automatic test_stray();
    do_reset();
    set_src(1, 1'b1, 1'b0, 1'b0, 64'hDEAD, '0);
    #1;
    n_checks++;
    if ({s0_rdy, s1_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL stray1_rdy: got %b%b expected 01", s0_rdy, s1_rdy);
    end
    tick();
    exp_drops++;
    n_checks++;
    if (pkt_tx_val !== 1'b0 || drop_err !== 1'b1) begin
      n_fail++; $display("FAIL stray1_drop: got val=%b drop=%b expected val=0 drop=1", pkt_tx_val, drop_err);
    end
    check_stats("stray1");
    idle_inputs();
    tick();
    n_checks++;
    if (drop_err !== 1'b0) begin
      n_fail++; $display("FAIL stray1_pulse: got drop=%b expected 0", drop_err);
    end
    set_src(0, 1'b1, 1'b0, 1'b0, 64'h1, '0);
    set_src(1, 1'b1, 1'b0, 1'b0, 64'h2, '0);
    #1;
    n_checks++;
    if ({s0_rdy, s1_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL stray_both_rdy: got %b%b expected 10", s0_rdy, s1_rdy);
    end
    tick();
    exp_drops++;
    set_src(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (drop_err !== 1'b1 || {s0_rdy, s1_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL stray_both_second: got drop=%b rdy=%b%b expected drop=1 rdy=01", drop_err, s0_rdy, s1_rdy);
    end
    tick();
    exp_drops++;
    set_src(0, 1'b1, 1'b0, 1'b0, 64'h3, '0);
    set_src(1, 1'b1, 1'b1, 1'b1, 64'hCAFE, MW'(2));
    #1;
    n_checks++;
    if (drop_err !== 1'b1 || {s0_rdy, s1_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL stray_vs_cand: got drop=%b rdy=%b%b expected drop=1 rdy=01", drop_err, s0_rdy, s1_rdy);
    end
    tick();
    exp_pkt1++;
    model_last = 1;
    n_checks++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err} !== 4'b1110 || pkt_tx_data !== 64'hCAFE) begin
      n_fail++; $display("FAIL stray_cand_out: got val/sop/eop/drop=%b%b%b%b data=%h expected 1110 cafe",
                         pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err, pkt_tx_data);
    end
    idle_inputs();
    tick();
    check_stats("stray");
    $display("test_stray: drops=%0d", exp_drops);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_src(0, 1'b1, i == 0, 1'b0, DW'(16 + i), '0);
      tick();
      n_checks++;
      if (pkt_tx_val !== 1'b1 || pkt_tx_data !== DW'(16 + i)) begin
        n_fail++; $display("FAIL midrst_beat%0d: got val=%b data=%h expected val=1 data=%h",
                           i, pkt_tx_val, pkt_tx_data, DW'(16 + i));
      end
    end
    set_src(0, 1'b1, 1'b0, 1'b0, DW'(18), '0);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err, s0_rdy, s1_rdy} !== 6'b0 ||
        pkt_tx_data !== '0 || pkt_tx_mod !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got val=%b sop=%b eop=%b drop=%b rdy=%b%b data=%h expected all 0",
               pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err, s0_rdy, s1_rdy, pkt_tx_data);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    model_last = 1;
    exp_drops = 0; exp_pkt0 = 0; exp_pkt1 = 0;
    $display("test_reset_mid_packet: reset applied");
    add_packet(1, 3);
    run_stream("test_reset_mid_packet", 0, 64'h0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6; i++) add_packet(0, $urandom_range(1, 5));
    for (int i = 0; i < 5; i++) add_packet(1, $urandom_range(1, 5));
    run_stream("test_random", 30, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_single_beat();
    test_stray();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
